// File: rtl/packet_buffer_ctrl_pkg.sv
// Shared definitions for the packet buffer controller: default depth,
// frame header length, FSM state encodings and a saturating counter helper.
package packet_buffer_ctrl_pkg;

    localparam int DEFAULT_SIZE = 1024;
    localparam int HDR_LEN      = 2;

    typedef enum logic [1:0] {
        W_DATA   = 2'd0,
        W_HDR_HI = 2'd1,
        W_HDR_LO = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_HDR_HI = 2'd1,
        R_HDR_LO = 2'd2,
        R_DATA   = 2'd3
    } rd_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : (value + 16'd1);
    endfunction

endpackage

// File: rtl/packet_buffer_ctrl_memory_block.sv
// Two-port byte memory: one synchronous write port and one synchronous read
// port with one cycle of latency. The read data holds while rd_en is low.
module memory_block
    import packet_buffer_ctrl_pkg::*;
#(
    parameter int SIZE = DEFAULT_SIZE,
    parameter int AW   = $clog2(SIZE)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem_r [SIZE];

    // Write port: store the byte when enabled.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read port: fetch on enable, otherwise keep the last fetched byte.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/packet_buffer_ctrl.sv
// Store-and-forward frame buffer. Each frame is kept as a 2-byte big-endian
// length header followed by its payload in a circular byte memory. Frames
// become visible to the reader only once complete and not dropped.
module packet_buffer_ctrl
    import packet_buffer_ctrl_pkg::*;
#(
    parameter int SIZE = DEFAULT_SIZE,
    parameter int AW   = $clog2(SIZE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    input  logic          in_last,
    input  logic          in_drop,
    output logic          in_ready,
    output logic [7:0]    out_data,
    output logic          out_valid,
    output logic          out_last,
    input  logic          out_ready,
    output logic [AW-1:0] frames_pending,
    output logic [15:0]   drop_count
);

    localparam logic [AW:0] HDR_W  = (AW+1)'(HDR_LEN);
    localparam logic [AW:0] SIZE_W = (AW+1)'(SIZE);
    localparam logic [AW:0] ONE_W  = (AW+1)'(1);

    // wr_cur counts payload bytes from wr_base; the payload of the open frame
    // sits HDR_LEN bytes above it, behind the space reserved for the header.
    wr_state_t     wr_state_r, wr_state_s;
    rd_state_t     rd_state_r, rd_state_s;
    logic [AW:0]   wr_base_r, wr_cur_r, rd_ptr_r;
    logic [AW:0]   used_s, frame_len_s;
    logic          full_s, in_fire_s, in_ready_r, overflow_r;
    logic          byte_wr_s, drop_s, commit_s, ovf_set_s;
    logic [15:0]   frame_len_r, drop_count_r, cnt_r, hdr_len_s;
    logic [7:0]    hdr_hi_r;
    logic [AW-1:0] pending_r, pending_after_s;
    logic          out_valid_r, out_last_r, xfer_s, last_xfer_s;
    logic          mem_wr_en_s, mem_rd_en_s;
    logic [AW-1:0] mem_wr_addr_s, mem_rd_addr_s;
    logic [7:0]    mem_wr_data_s, mem_rd_data_s;

    // Occupancy includes the header space of the frame being written.
    assign used_s      = wr_cur_r + HDR_W - rd_ptr_r;
    assign full_s      = (used_s >= SIZE_W);
    assign in_fire_s   = in_valid & in_ready_r;
    assign frame_len_s = wr_cur_r + ONE_W - wr_base_r;
    assign xfer_s      = out_valid_r & out_ready;
    assign last_xfer_s = xfer_s & out_last_r;
    assign hdr_len_s   = {hdr_hi_r, mem_rd_data_s};
    assign pending_after_s = pending_r + AW'(commit_s) - AW'(last_xfer_s);

    assign in_ready       = in_ready_r;
    assign out_valid      = out_valid_r;
    assign out_last       = out_last_r;
    assign out_data       = mem_rd_data_s & {8{out_valid_r}};
    assign frames_pending = pending_r;
    assign drop_count     = drop_count_r;

    // Write FSM: payload write, overflow/drop decisions and header write-back.
    always_comb begin
        wr_state_s    = wr_state_r;
        mem_wr_en_s   = 1'b0;
        mem_wr_addr_s = AW'(wr_cur_r + HDR_W);
        mem_wr_data_s = in_data;
        byte_wr_s     = 1'b0;
        drop_s        = 1'b0;
        commit_s      = 1'b0;
        ovf_set_s     = 1'b0;
        case (wr_state_r)
            W_DATA: begin
                if (in_fire_s) begin
                    if (full_s || overflow_r) begin
                        drop_s    = in_last;
                        ovf_set_s = ~in_last;
                    end else begin
                        mem_wr_en_s = 1'b1;
                        byte_wr_s   = 1'b1;
                        drop_s      = in_last & in_drop;
                        wr_state_s  = (in_last && !in_drop) ? W_HDR_HI : W_DATA;
                    end
                end else begin
                    wr_state_s = W_DATA;
                end
            end
            W_HDR_HI: begin
                mem_wr_en_s   = 1'b1;
                mem_wr_addr_s = AW'(wr_base_r);
                mem_wr_data_s = frame_len_r[15:8];
                wr_state_s    = W_HDR_LO;
            end
            W_HDR_LO: begin
                mem_wr_en_s   = 1'b1;
                mem_wr_addr_s = AW'(wr_base_r + ONE_W);
                mem_wr_data_s = frame_len_r[7:0];
                commit_s      = 1'b1;
                wr_state_s    = W_DATA;
            end
            default: begin
                wr_state_s = W_DATA;
            end
        endcase
    end

    // Write-side state: pointers, overflow flag, frame length and drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_r   <= W_DATA;
            in_ready_r   <= 1'b0;
            wr_base_r    <= '0;
            wr_cur_r     <= '0;
            overflow_r   <= 1'b0;
            frame_len_r  <= 16'd0;
            drop_count_r <= 16'd0;
        end else begin
            wr_state_r <= wr_state_s;
            in_ready_r <= (wr_state_s == W_DATA);
            if (drop_s) begin
                wr_cur_r     <= wr_base_r;
                overflow_r   <= 1'b0;
                drop_count_r <= sat_inc16(drop_count_r);
            end else if (commit_s) begin
                wr_base_r <= wr_cur_r + HDR_W;
                wr_cur_r  <= wr_cur_r + HDR_W;
            end else if (byte_wr_s) begin
                wr_cur_r    <= wr_cur_r + ONE_W;
                frame_len_r <= 16'(frame_len_s);
            end else if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Committed-frame count; a commit and a final-byte read cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= '0;
        end else begin
            pending_r <= pending_after_s;
        end
    end

    // Read FSM: header fetch, payload prefetch and read-address hold on stall.
    always_comb begin
        rd_state_s    = rd_state_r;
        mem_rd_en_s   = 1'b0;
        mem_rd_addr_s = AW'(rd_ptr_r);
        case (rd_state_r)
            R_IDLE: begin
                if (pending_r != '0) begin
                    mem_rd_en_s = 1'b1;
                    rd_state_s  = R_HDR_HI;
                end else begin
                    rd_state_s = R_IDLE;
                end
            end
            R_HDR_HI: begin
                mem_rd_en_s   = 1'b1;
                mem_rd_addr_s = AW'(rd_ptr_r + ONE_W);
                rd_state_s    = R_HDR_LO;
            end
            R_HDR_LO: begin
                mem_rd_en_s   = 1'b1;
                mem_rd_addr_s = AW'(rd_ptr_r + HDR_W);
                rd_state_s    = R_DATA;
            end
            R_DATA: begin
                mem_rd_addr_s = AW'(rd_ptr_r + ONE_W);
                if (xfer_s) begin
                    if (out_last_r) begin
                        mem_rd_en_s = (pending_after_s != '0);
                        rd_state_s  = (pending_after_s != '0) ? R_HDR_HI : R_IDLE;
                    end else begin
                        mem_rd_en_s = 1'b1;
                        rd_state_s  = R_DATA;
                    end
                end else begin
                    rd_state_s = R_DATA;
                end
            end
            default: begin
                rd_state_s = R_IDLE;
            end
        endcase
    end

    // Read-side state: pointer, header capture, byte countdown and output flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_r  <= R_IDLE;
            rd_ptr_r    <= '0;
            hdr_hi_r    <= 8'd0;
            cnt_r       <= 16'd0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            rd_state_r <= rd_state_s;
            case (rd_state_r)
                R_HDR_HI: begin
                    hdr_hi_r <= mem_rd_data_s;
                end
                R_HDR_LO: begin
                    cnt_r       <= hdr_len_s - 16'd1;
                    out_last_r  <= (hdr_len_s == 16'd1);
                    out_valid_r <= 1'b1;
                    rd_ptr_r    <= rd_ptr_r + HDR_W;
                end
                R_DATA: begin
                    if (xfer_s) begin
                        rd_ptr_r <= rd_ptr_r + ONE_W;
                        if (out_last_r) begin
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                        end else begin
                            cnt_r      <= cnt_r - 16'd1;
                            out_last_r <= (cnt_r == 16'd1);
                        end
                    end
                end
                default: begin
                    hdr_hi_r <= hdr_hi_r;
                end
            endcase
        end
    end

    memory_block #(
        .SIZE (SIZE),
        .AW   (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_wr_en_s),
        .wr_addr (mem_wr_addr_s),
        .wr_data (mem_wr_data_s),
        .rd_en   (mem_rd_en_s),
        .rd_addr (mem_rd_addr_s),
        .rd_data (mem_rd_data_s)
    );

endmodule

// File: tb/tb_packet_buffer_ctrl.sv
// Bench for packet_buffer_ctrl with a 64-byte buffer: a frame table driven
// through the write side, a byte scoreboard on the read side, a stall
// stability monitor, and hand sequences for reset and back-to-back frames.
module tb_packet_buffer_ctrl;

    localparam int SIZE = 64;
    localparam int AW   = 6;

    logic          clk, rst_n;
    logic [7:0]    in_data;
    logic          in_valid, in_last, in_drop, in_ready;
    logic [7:0]    out_data;
    logic          out_valid, out_last, out_ready;
    logic [AW-1:0] frames_pending;
    logic [15:0]   drop_count;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    typedef struct {
        int len;
        bit drop;
        int ready_pct;
        bit deliver;
        int drops_after;
    } vec_t;

    exp_t q[$];
    vec_t vecs[14];
    int   checks = 0;
    int   errors = 0;
    int   ready_pct = 100;

    packet_buffer_ctrl #(.SIZE(SIZE)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_last        (in_last),
        .in_drop        (in_drop),
        .in_ready       (in_ready),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_last       (out_last),
        .out_ready      (out_ready),
        .frames_pending (frames_pending),
        .drop_count     (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Consumer-side ready, re-randomised every cycle at the current rate.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = (int'($urandom_range(99)) < ready_pct);
        end
    end

    // Read-side monitor: scoreboard compare on transfer, hold check on stall.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        logic       prev_last;
        exp_t       e;
        prev_stall = 1'b0;
        prev_data  = 8'd0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_data", 32'(out_data), 32'(prev_data));
                    check("stall_last", 32'(out_last), 32'(prev_last));
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_byte: got %0h, expected no byte", out_data);
                    end else begin
                        e = q.pop_front();
                        check("out_data", 32'(out_data), 32'(e.data));
                        check("out_last", 32'(out_last), 32'(e.last));
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_last  = out_last;
            end
        end
    end

    // Present one byte and hold it until accepted; counts not-ready cycles.
    task automatic drive_byte(input logic [7:0] d, input logic last, input logic drop,
                              inout int waits);
        int guard;
        guard    = 0;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        in_drop  = drop;
        while (!in_ready && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
            waits++;
        end
        if (!in_ready) fail_now("in_ready_wait");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_drop  = 1'b0;
    endtask

    task automatic send_frame(input int fid, input int len, input bit drop,
                              input bit deliver, output int waits);
        logic [7:0] d;
        logic       last;
        waits = 0;
        for (int k = 0; k < len; k++) begin
            d    = 8'(fid * 16 + k + 1);
            last = (k == len - 1);
            if (deliver) q.push_back('{data: d, last: last});
            drive_byte(d, last, drop && last, waits);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || frames_pending != '0 || out_valid) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 3000) fail_now("drain");
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_pending", 32'(frames_pending), 32'd0);
        check("rst_drops", 32'(drop_count), 32'd0);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rel_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("rel_in_ready_high", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int w;
        int n;
        vecs[0]  = '{4,  1'b0, 100, 1'b1, 0};
        vecs[1]  = '{3,  1'b1, 100, 1'b0, 1};
        vecs[2]  = '{4,  1'b0, 100, 1'b1, 1};
        vecs[3]  = '{70, 1'b0, 100, 1'b0, 2};
        vecs[4]  = '{10, 1'b0, 100, 1'b1, 2};
        vecs[5]  = '{62, 1'b0, 60,  1'b1, 2};
        vecs[6]  = '{63, 1'b0, 100, 1'b0, 3};
        vecs[7]  = '{1,  1'b0, 100, 1'b1, 3};
        vecs[8]  = '{20, 1'b0, 50,  1'b1, 3};
        vecs[9]  = '{37, 1'b0, 40,  1'b1, 3};
        vecs[10] = '{25, 1'b0, 70,  1'b1, 3};
        vecs[11] = '{50, 1'b0, 30,  1'b1, 3};
        vecs[12] = '{5,  1'b1, 50,  1'b0, 4};
        vecs[13] = '{30, 1'b0, 50,  1'b1, 4};

        rst_n    = 1'b0;
        in_data  = 8'd0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_drop  = 1'b0;
        #23;
        do_reset();

        // 5-byte frame held back by the consumer, then released.
        ready_pct = 0;
        repeat (2) @(posedge clk);
        #1;
        send_frame(0, 5, 1'b0, 1'b1, w);
        repeat (8) @(posedge clk);
        #1;
        check("pending_one", 32'(frames_pending), 32'd1);
        check("held_valid", 32'(out_valid), 32'd1);
        check("held_first", 32'(out_data), 32'h01);
        ready_pct = 100;
        drain();
        check("pending_zero", 32'(frames_pending), 32'd0);

        for (int i = 0; i < 14; i++) begin
            ready_pct = vecs[i].ready_pct;
            send_frame(i + 1, vecs[i].len, vecs[i].drop, vecs[i].deliver, w);
            if (vecs[i].len > SIZE - 2) check("ovf_in_ready_waits", 32'(w), 32'd0);
            drain();
            check("drop_count", 32'(drop_count), 32'(vecs[i].drops_after));
        end

        // Twenty 1-byte frames back to back.
        ready_pct = 100;
        for (int f = 0; f < 20; f++) begin
            send_frame(100 + f, 1, 1'b0, 1'b1, w);
        end
        drain();
        check("b2b_drops", 32'(drop_count), 32'd4);

        // Reset in the middle of writing a frame.
        w = 0;
        for (int k = 0; k < 3; k++) drive_byte(8'(8'hA0 + k), 1'b0, 1'b0, w);
        do_reset();
        send_frame(50, 6, 1'b0, 1'b1, w);
        drain();
        check("post_wr_reset_drops", 32'(drop_count), 32'd0);

        // Reset in the middle of reading a frame.
        send_frame(60, 20, 1'b0, 1'b1, w);
        n = 0;
        while (q.size() > 14 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) fail_now("mid_read_wait");
        do_reset();
        send_frame(61, 6, 1'b0, 1'b1, w);
        drain();
        check("post_rd_reset_drops", 32'(drop_count), 32'd0);
        check("final_pending", 32'(frames_pending), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
